// File: rtl/decoder_scan_if.sv
// Bus bundle for decoder_scan: enables, mode/select/dwell controls and the
// registered decoded outputs.
interface decoder_scan_if #(
  parameter int SEL_W   = 3,
  parameter int OUT_N   = 8,
  parameter int DWELL_W = 16
);
  logic               G1;
  logic               G2A;
  logic               G2B;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_N-1:0]   Y;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  modport master (
    output G1, G2A, G2B, mode, sel, dwell,
    input  Y, idx, wrap
  );

  modport slave (
    input  G1, G2A, G2B, mode, sel, dwell,
    output Y, idx, wrap
  );
endinterface

// File: rtl/decoder_scan.sv
// Registered enable-gated one-hot decoder with an optional self-scanning mode
// that steps the active line every dwell+1 enabled cycles.
module decoder_scan #(
  parameter int SEL_W      = 3,
  parameter int OUT_N      = 8,
  parameter int DWELL_W    = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_if.slave  bus
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_N - 1);
  localparam logic [OUT_N-1:0] IDLE_Y   = {OUT_N{ACTIVE_LOW}};

  logic               en;
  logic               scan_entry;
  logic               mode_q;
  logic               wrap_q, wrap_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] pre_q, pre_d;
  logic [OUT_N-1:0]   y_q, y_d;
  logic [OUT_N-1:0]   hot;

  assign en         = bus.G1 & bus.G2A & bus.G2B;
  assign scan_entry = bus.mode & ~mode_q;

  // Next index / prescaler / wrap.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    idx_d  = idx_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    if (!bus.mode) begin
      pre_d = '0;
      if (en) idx_d = bus.sel;
    end else if (en) begin
      if (scan_entry) begin
        idx_d = '0;
        pre_d = '0;
      end else if (pre_q >= bus.dwell) begin
        // '>=' makes an overshoot after a dwell decrease terminal at once.
        pre_d = '0;
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end else begin
        pre_d = pre_q + DWELL_W'(1);
      end
    end
  end

  // Y decodes the next index, so Y and idx update on the same edge; an
  // out-of-range index matches no line and leaves Y inactive.
  always_comb begin
    hot = '0;
    for (int i = 0; i < OUT_N; i++) begin
      hot[i] = en && (int'(idx_d) == i);
    end
    y_d = hot ^ IDLE_Y;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    if (!rst_n) begin
      mode_q <= 1'b0;
      idx_q  <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
      y_q    <= IDLE_Y;
    end else begin
      mode_q <= bus.mode;
      idx_q  <= idx_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
      y_q    <= y_d;
    end
  end

  assign bus.Y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: default 8-line active-high instance plus a
// 5-line active-low instance sharing clock and reset.
module tb_decoder_scan;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  decoder_scan_if #(.SEL_W(3), .OUT_N(8), .DWELL_W(16)) bus8 ();
  decoder_scan_if #(.SEL_W(3), .OUT_N(5), .DWELL_W(16)) bus5 ();

  decoder_scan #(.SEL_W(3), .OUT_N(8), .DWELL_W(16), .ACTIVE_LOW(1'b0)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  decoder_scan #(.SEL_W(3), .OUT_N(5), .DWELL_W(16), .ACTIVE_LOW(1'b1)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.G1 = 1'b1; bus8.G2A = 1'b1; bus8.G2B = 1'b1;
    bus8.mode = 1'b0; bus8.sel = 3'd0; bus8.dwell = 16'd0;
    bus5.G1 = 1'b1; bus5.G2A = 1'b1; bus5.G2B = 1'b1;
    bus5.mode = 1'b0; bus5.sel = 3'd0; bus5.dwell = 16'd0;
    tick();
    tick();
    checks++;
    if (bus8.Y !== 8'h00) begin errors++; $display("FAIL reset_y8 got=%h exp=00", bus8.Y); end
    checks++;
    if (bus8.idx !== 3'd0) begin errors++; $display("FAIL reset_idx8 got=%0d exp=0", bus8.idx); end
    checks++;
    if (bus8.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap8 got=%b exp=0", bus8.wrap); end
    checks++;
    if (bus5.Y !== 5'b11111) begin errors++; $display("FAIL reset_y5 got=%b exp=11111", bus5.Y); end
    rst_n = 1'b1;
  endtask

  task automatic test_direct_sweep();
    logic [7:0] exp_y;
    for (int s = 0; s < 8; s++) begin
      bus8.sel = 3'(s);
      tick();
      exp_y = 8'h01 << s;
      checks++;
      if (bus8.Y !== exp_y) begin errors++; $display("FAIL direct_y sel=%0d got=%h exp=%h", s, bus8.Y, exp_y); end
      checks++;
      if (bus8.idx !== 3'(s)) begin errors++; $display("FAIL direct_idx sel=%0d got=%0d exp=%0d", s, bus8.idx, s); end
    end
  endtask

  task automatic test_enable_gating();
    bus8.sel = 3'd5;
    for (int g = 0; g < 3; g++) begin
      bus8.G1 = 1'b1; bus8.G2A = 1'b1; bus8.G2B = 1'b1;
      tick();
      checks++;
      if (bus8.Y !== 8'h20) begin errors++; $display("FAIL gate_on g=%0d got=%h exp=20", g, bus8.Y); end
      case (g)
        0: bus8.G2B = 1'b0;
        1: bus8.G1  = 1'b0;
        default: bus8.G2A = 1'b0;
      endcase
      tick();
      checks++;
      if (bus8.Y !== 8'h00) begin errors++; $display("FAIL gate_off g=%0d got=%h exp=00", g, bus8.Y); end
      checks++;
      if (bus8.idx !== 3'd5) begin errors++; $display("FAIL gate_idx g=%0d got=%0d exp=5", g, bus8.idx); end
      bus8.G1 = 1'b1; bus8.G2A = 1'b1; bus8.G2B = 1'b1;
      tick();
      checks++;
      if (bus8.Y !== 8'h20) begin errors++; $display("FAIL gate_back g=%0d got=%h exp=20", g, bus8.Y); end
    end
  endtask

  task automatic test_scan_dwell2();
    logic [2:0] exp_idx;
    logic [7:0] exp_y;
    logic       exp_wrap;
    bus8.dwell = 16'd2;
    bus8.mode  = 1'b1;
    for (int c = 0; c < 27; c++) begin
      tick();
      exp_idx  = 3'((c / 3) % 8);
      exp_y    = 8'h01 << exp_idx;
      exp_wrap = (c == 24);
      checks++;
      if (bus8.Y !== exp_y) begin errors++; $display("FAIL scan2_y c=%0d got=%h exp=%h", c, bus8.Y, exp_y); end
      checks++;
      if (bus8.idx !== exp_idx) begin errors++; $display("FAIL scan2_idx c=%0d got=%0d exp=%0d", c, bus8.idx, exp_idx); end
      checks++;
      if (bus8.wrap !== exp_wrap) begin errors++; $display("FAIL scan2_wrap c=%0d got=%b exp=%b", c, bus8.wrap, exp_wrap); end
    end
    bus8.mode = 1'b0;
    bus8.sel  = 3'd6;
    tick();
    checks++;
    if (bus8.Y !== 8'h40) begin errors++; $display("FAIL scan_to_direct got=%h exp=40", bus8.Y); end
  endtask

  task automatic test_freeze_dwell0();
    logic [7:0] exp_y;
    bus8.dwell = 16'd0;
    bus8.mode  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      exp_y = 8'h01 << c;
      checks++;
      if (bus8.Y !== exp_y) begin errors++; $display("FAIL dw0_y c=%0d got=%h exp=%h", c, bus8.Y, exp_y); end
    end
    bus8.G1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus8.Y !== 8'h00 || bus8.idx !== 3'd3 || bus8.wrap !== 1'b0) begin
        errors++;
        $display("FAIL freeze c=%0d got y=%h idx=%0d wrap=%b exp y=00 idx=3 wrap=0", c, bus8.Y, bus8.idx, bus8.wrap);
      end
    end
    bus8.G1 = 1'b1;
    tick();
    checks++;
    if (bus8.Y !== 8'h10 || bus8.idx !== 3'd4) begin
      errors++; $display("FAIL resume1 got y=%h idx=%0d exp y=10 idx=4", bus8.Y, bus8.idx);
    end
    tick();
    checks++;
    if (bus8.Y !== 8'h20 || bus8.idx !== 3'd5) begin
      errors++; $display("FAIL resume2 got y=%h idx=%0d exp y=20 idx=5", bus8.Y, bus8.idx);
    end
  endtask

  task automatic test_out5_active_low();
    logic [2:0] exp_idx;
    logic [4:0] exp_y;
    bus5.sel = 3'd6;
    tick();
    checks++;
    if (bus5.Y !== 5'b11111 || bus5.idx !== 3'd6) begin
      errors++; $display("FAIL out5_oob got y=%b idx=%0d exp y=11111 idx=6", bus5.Y, bus5.idx);
    end
    bus5.sel = 3'd2;
    tick();
    checks++;
    if (bus5.Y !== 5'b11011) begin errors++; $display("FAIL out5_sel2 got=%b exp=11011", bus5.Y); end
    bus5.mode = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      exp_idx = 3'(c % 5);
      exp_y   = ~(5'b00001 << exp_idx);
      checks++;
      if (bus5.Y !== exp_y || bus5.idx !== exp_idx || bus5.wrap !== (c == 5)) begin
        errors++;
        $display("FAIL out5_scan c=%0d got y=%b idx=%0d wrap=%b exp y=%b idx=%0d wrap=%b",
                 c, bus5.Y, bus5.idx, bus5.wrap, exp_y, exp_idx, (c == 5));
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int waited = 0;
    while (bus8.idx !== 3'd6 && waited < 16) begin
      tick();
      waited++;
    end
    checks++;
    if (bus8.idx !== 3'd6) begin errors++; $display("FAIL reach_idx6 timeout idx=%0d exp=6", bus8.idx); end
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus8.Y !== 8'h40 || bus8.idx !== 3'd6) begin
      errors++; $display("FAIL pre_edge_reset got y=%h idx=%0d exp y=40 idx=6", bus8.Y, bus8.idx);
    end
    tick();
    checks++;
    if (bus8.Y !== 8'h00 || bus8.idx !== 3'd0 || bus8.wrap !== 1'b0) begin
      errors++; $display("FAIL mid_reset got y=%h idx=%0d wrap=%b exp y=00 idx=0 wrap=0", bus8.Y, bus8.idx, bus8.wrap);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus8.Y !== 8'h01 || bus8.idx !== 3'd0) begin
      errors++; $display("FAIL restart0 got y=%h idx=%0d exp y=01 idx=0", bus8.Y, bus8.idx);
    end
    tick();
    checks++;
    if (bus8.Y !== 8'h02 || bus8.idx !== 3'd1) begin
      errors++; $display("FAIL restart1 got y=%h idx=%0d exp y=02 idx=1", bus8.Y, bus8.idx);
    end
  endtask

  initial begin
    test_reset();
    test_direct_sweep();
    test_enable_gating();
    test_scan_dwell2();
    test_freeze_dwell0();
    test_out5_active_low();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timeout");
  end

endmodule
